pmem_slave: RTL and testbench

PMEM_SLAVE -- requirements
Module: pmem_slave

---
 rtl/pmem_pkg.sv | 19 +
 rtl/pmem_array.sv | 54 +++++
 rtl/pmem_slave.sv | 155 +++++++++++++++
 tb/tb_pmem_slave.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmem_pkg.sv
// ---------------------------------------------------------------------------
// pmem_pkg
// Shared definitions for the pmem_slave block: the request/response FSM state
// type and the default parameter values used by the top and its storage array.
// ---------------------------------------------------------------------------
package pmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_MEM_SIZE   = 16;
  localparam int DEF_RD_LATENCY = 1;

endpackage

// File: rtl/pmem_array.sv
// ---------------------------------------------------------------------------
// pmem_array
// Word-addressed storage with a byte-enabled synchronous write port, an
// asynchronous read port and an asynchronous clear that zeroes every word.
//
// Ports:
//   clk       input   write clock, rising edge
//   clear_i   input   asynchronous clear of all words (active-high)
//   we_i      input   write enable (caller guarantees waddr_i is in range)
//   waddr_i   input   write word address
//   wdata_i   input   write data
//   wstrb_i   input   byte enables, bit b covers bits 8b+7..8b
//   raddr_i   input   read word address
//   rdata_o   output  read data, 0 when raddr_i is out of range
// ---------------------------------------------------------------------------
module pmem_array
  import pmem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MEM_SIZE   = DEF_MEM_SIZE
) (
  input  logic                    clk,
  input  logic                    clear_i,
  input  logic                    we_i,
  input  logic [ADDR_WIDTH-1:0]   waddr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  input  logic [ADDR_WIDTH-1:0]   raddr_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [MEM_SIZE];

  always_ff @(posedge clk or posedge clear_i) begin
    if (clear_i) begin
      for (int i = 0; i < MEM_SIZE; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (wstrb_i[b]) begin
          mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  // MEM_SIZE may be smaller than the address space, so guard the read index.
  assign rdata_o = (32'(raddr_i) < MEM_SIZE) ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/pmem_slave.sv
// ---------------------------------------------------------------------------
// pmem_slave
// Single-outstanding memory slave with valid/ready request and response
// channels. Writes commit on the accept edge; the response (read data, error,
// write echo) appears RD_LATENCY cycles after accept and is held until the
// master takes it with rsp_ready.
//
// Ports:
//   clk        input   clock, rising edge
//   reset      input   asynchronous active-high reset (also clears memory)
//   req_valid  input   request present
//   req_ready  output  slave can accept (only in IDLE)
//   req_wr     input   1 = write, 0 = read
//   req_addr   input   word address
//   req_wdata  input   write data
//   req_strb   input   byte write enables
//   rsp_valid  output  response present
//   rsp_ready  input   master accepts response
//   rsp_rdata  output  read data (0 for writes, errors and when idle)
//   rsp_err    output  address was out of range
//   rsp_wr     output  echo of req_wr of the answered request
// ---------------------------------------------------------------------------
module pmem_slave
  import pmem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MEM_SIZE   = DEF_MEM_SIZE,
  parameter int RD_LATENCY = DEF_RD_LATENCY
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_wr,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_strb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_wr
);

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    wr_q;
  logic                    err_q;
  logic                    rsp_valid_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;
  logic                    rsp_err_q;
  logic                    rsp_wr_q;

  logic                    rsp_wr_d;
  logic                    rsp_err_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_d;

  logic                    accept;
  logic                    req_in_range;
  logic [ADDR_WIDTH-1:0]   arr_raddr;
  logic [DATA_WIDTH-1:0]   arr_rdata;

  assign accept       = (state_q == IDLE) && req_valid;
  assign req_in_range = 32'(req_addr) < MEM_SIZE;

  // In IDLE the array is read straight from the request so a latency-1
  // response can be loaded on the accept edge; later it uses the captured
  // address. Nothing writes between accept and response, so both views agree.
  assign arr_raddr = (state_q == IDLE) ? req_addr : addr_q;

  pmem_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_SIZE   (MEM_SIZE)
  ) u_array (
    .clk     (clk),
    .clear_i (reset),
    .we_i    (accept && req_wr && req_in_range),
    .waddr_i (req_addr),
    .wdata_i (req_wdata),
    .wstrb_i (req_strb),
    .raddr_i (arr_raddr),
    .rdata_o (arr_rdata)
  );

  // Response payload about to be loaded: live request fields when loading on
  // the accept edge, captured fields when leaving WAIT.
  always_comb begin
    rsp_wr_d  = wr_q;
    rsp_err_d = err_q;
    if (state_q == IDLE) begin
      rsp_wr_d  = req_wr;
      rsp_err_d = !req_in_range;
    end
    rsp_rdata_d = (rsp_wr_d || rsp_err_d) ? '0 : arr_rdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wr_q        <= 1'b0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_wr_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q <= req_addr;
            wr_q   <= req_wr;
            err_q  <= !req_in_range;
            if (RD_LATENCY == 1) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= rsp_rdata_d;
              rsp_err_q   <= rsp_err_d;
              rsp_wr_q    <= rsp_wr_d;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          state_q     <= RESP;
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= rsp_rdata_d;
          rsp_err_q   <= rsp_err_d;
          rsp_wr_q    <= rsp_wr_d;
        end
        RESP: begin
          // Payload is cleared on hand-off so outputs read 0 while idle.
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_wr_q    <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_wr    = rsp_wr_q;

endmodule

// File: tb/tb_pmem_slave.sv
// ---------------------------------------------------------------------------
// tb_pmem_slave
// Two instances share a clock: index 0 has RD_LATENCY=1 and MEM_SIZE=12,
// index 1 has RD_LATENCY=2 and MEM_SIZE=14. Each is driven through its own
// signal slice and compared with a word-array model of the memory.
// ---------------------------------------------------------------------------
module tb_pmem_slave;

  logic              clk;
  logic [1:0]        reset;
  logic [1:0]        reqValid;
  logic [1:0]        reqReady;
  logic [1:0]        reqWr;
  logic [1:0][3:0]   reqAddr;
  logic [1:0][31:0]  reqWdata;
  logic [1:0][3:0]   reqStrb;
  logic [1:0]        rspValid;
  logic [1:0]        rspReady;
  logic [1:0][31:0]  rspRdata;
  logic [1:0]        rspErr;
  logic [1:0]        rspWr;

  int checks;
  int errors;

  int memSize [2] = '{12, 14};
  int lat     [2] = '{1, 2};
  logic [31:0] model [2][16];

  pmem_slave #(
    .ADDR_WIDTH (4), .DATA_WIDTH (32), .MEM_SIZE (12), .RD_LATENCY (1)
  ) u_dut0 (
    .clk       (clk),
    .reset     (reset[0]),
    .req_valid (reqValid[0]),
    .req_ready (reqReady[0]),
    .req_wr    (reqWr[0]),
    .req_addr  (reqAddr[0]),
    .req_wdata (reqWdata[0]),
    .req_strb  (reqStrb[0]),
    .rsp_valid (rspValid[0]),
    .rsp_ready (rspReady[0]),
    .rsp_rdata (rspRdata[0]),
    .rsp_err   (rspErr[0]),
    .rsp_wr    (rspWr[0])
  );

  pmem_slave #(
    .ADDR_WIDTH (4), .DATA_WIDTH (32), .MEM_SIZE (14), .RD_LATENCY (2)
  ) u_dut1 (
    .clk       (clk),
    .reset     (reset[1]),
    .req_valid (reqValid[1]),
    .req_ready (reqReady[1]),
    .req_wr    (reqWr[1]),
    .req_addr  (reqAddr[1]),
    .req_wdata (reqWdata[1]),
    .req_strb  (reqStrb[1]),
    .rsp_valid (rspValid[1]),
    .rsp_ready (rspReady[1]),
    .rsp_rdata (rspRdata[1]),
    .rsp_err   (rspErr[1]),
    .rsp_wr    (rspWr[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clearModel(input int d);
    for (int a = 0; a < 16; a++) model[d][a] = 32'h0;
  endtask

  // Applies one accepted request to the model and returns the response it must produce.
  task automatic modelAccess(input int d, input logic wr, input logic [3:0] addr,
                             input logic [31:0] wdata, input logic [3:0] strb,
                             output logic [31:0] eData, output logic eErr);
    logic inRange;
    inRange = int'(addr) < memSize[d];
    if (wr && inRange) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) model[d][addr][8*b +: 8] = wdata[8*b +: 8];
      end
    end
    eErr  = !inRange;
    eData = (wr || !inRange) ? 32'h0 : model[d][addr];
  endtask

  // One full transaction; entered and left at #1 after a rising edge.
  task automatic applyStimulus(input int d, input logic wr, input logic [3:0] addr,
                               input logic [31:0] wdata, input logic [3:0] strb,
                               input int hold, input logic probe,
                               output logic [31:0] rdataObs);
    logic [31:0] eData;
    logic        eErr;
    int          n;
    checkOutput("idleReady", reqReady[d], 1);
    reqValid[d] = 1'b1;
    reqWr[d]    = wr;
    reqAddr[d]  = addr;
    reqWdata[d] = wdata;
    reqStrb[d]  = strb;
    rspReady[d] = 1'b0;
    @(posedge clk); #1;
    reqValid[d] = 1'b0;
    modelAccess(d, wr, addr, wdata, strb, eData, eErr);
    n = 1;
    while (!rspValid[d] && n < 8) begin
      checkOutput("busyReady", reqReady[d], 0);
      @(posedge clk); #1;
      n++;
    end
    checkOutput("latency", n, lat[d]);
    checkOutput("rspValid", rspValid[d], 1);
    checkOutput("rspRdata", rspRdata[d], eData);
    checkOutput("rspErr", rspErr[d], eErr);
    checkOutput("rspWr", rspWr[d], wr);
    checkOutput("respReady", reqReady[d], 0);
    rdataObs = rspRdata[d];
    for (int i = 0; i < hold; i++) begin
      if (probe) begin
        reqValid[d] = 1'b1;
        reqWr[d]    = 1'b1;
        reqAddr[d]  = 4'd7;
        reqWdata[d] = $urandom;
        reqStrb[d]  = 4'hF;
      end
      @(posedge clk); #1;
      checkOutput("holdValid", rspValid[d], 1);
      checkOutput("holdRdata", rspRdata[d], eData);
      checkOutput("holdErr", rspErr[d], eErr);
      checkOutput("holdReady", reqReady[d], 0);
    end
    reqValid[d] = 1'b0;
    rspReady[d] = 1'b1;
    @(posedge clk); #1;
    rspReady[d] = 1'b0;
    checkOutput("doneValid", rspValid[d], 0);
    checkOutput("doneRdata", rspRdata[d], 0);
    checkOutput("doneErr", rspErr[d], 0);
    checkOutput("doneWr", rspWr[d], 0);
    checkOutput("doneReady", reqReady[d], 1);
  endtask

  task automatic randomizeReq(input int d);
    reqWr[d]    = 1'($urandom_range(0, 1));
    reqAddr[d]  = 4'($urandom_range(0, 15));
    reqWdata[d] = $urandom;
    reqStrb[d]  = 4'($urandom_range(0, 15));
  endtask

  // Continuous requests with rsp_ready held high; checks accept spacing and ordering.
  task automatic applyBurst(input int d, input int n);
    logic [31:0] expData [$];
    logic        expErr  [$];
    logic        expWr   [$];
    logic [31:0] eData;
    logic        eErr;
    logic        acc;
    int          issued;
    int          done;
    int          lastAcc;
    issued  = 0;
    done    = 0;
    lastAcc = -1;
    rspReady[d] = 1'b1;
    randomizeReq(d);
    reqValid[d] = 1'b1;
    for (int c = 0; c < n * 4 + 10 && done < n; c++) begin
      acc = reqReady[d] && reqValid[d];
      @(posedge clk); #1;
      if (acc) begin
        modelAccess(d, reqWr[d], reqAddr[d], reqWdata[d], reqStrb[d], eData, eErr);
        expData.push_back(eData);
        expErr.push_back(eErr);
        expWr.push_back(reqWr[d]);
        if (lastAcc >= 0) checkOutput("burstSpacing", c - lastAcc, lat[d] + 1);
        lastAcc = c;
        issued++;
        if (issued < n) randomizeReq(d);
        else reqValid[d] = 1'b0;
      end
      if (rspValid[d]) begin
        checkOutput("burstPending", expData.size() > 0, 1);
        if (expData.size() > 0) begin
          checkOutput("burstRdata", rspRdata[d], expData.pop_front());
          checkOutput("burstErr", rspErr[d], expErr.pop_front());
          checkOutput("burstWr", rspWr[d], expWr.pop_front());
        end
        done++;
      end
    end
    checkOutput("burstCount", done, n);
    reqValid[d] = 1'b0;
    @(posedge clk); #1;
    rspReady[d] = 1'b0;
    checkOutput("burstIdle", reqReady[d], 1);
  endtask

  initial begin
    logic [31:0] obs;
    checks   = 0;
    errors   = 0;
    reset    = 2'b11;
    reqValid = '0;
    reqWr    = '0;
    reqAddr  = '0;
    reqWdata = '0;
    reqStrb  = '0;
    rspReady = '0;
    clearModel(0);
    clearModel(1);
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checkOutput("rstReady", reqReady[d], 1);
      checkOutput("rstValid", rspValid[d], 0);
      checkOutput("rstRdata", rspRdata[d], 0);
      checkOutput("rstErr", rspErr[d], 0);
      checkOutput("rstWr", rspWr[d], 0);
    end
    reset = 2'b00;

    $display("[TB] directed write/read and byte strobes");
    for (int d = 0; d < 2; d++) begin
      applyStimulus(d, 1'b1, 4'd3, 32'hDEADBEEF, 4'hF, 0, 1'b0, obs);
      applyStimulus(d, 1'b0, 4'd3, 32'h0, 4'h0, 0, 1'b0, obs);
      checkOutput("readBeef", obs, 32'hDEADBEEF);
      applyStimulus(d, 1'b1, 4'd5, 32'h11223344, 4'hF, 0, 1'b0, obs);
      applyStimulus(d, 1'b1, 4'd5, 32'hAABBCCDD, 4'h5, 0, 1'b0, obs);
      applyStimulus(d, 1'b1, 4'd5, 32'hFFFFFFFF, 4'h0, 0, 1'b0, obs);
      applyStimulus(d, 1'b0, 4'd5, 32'h0, 4'h0, 0, 1'b0, obs);
      checkOutput("readMerged", obs, 32'h11BB33DD);
    end

    $display("[TB] out-of-range access");
    applyStimulus(0, 1'b1, 4'd13, 32'h12345678, 4'hF, 0, 1'b0, obs);
    applyStimulus(0, 1'b0, 4'd13, 32'h0, 4'h0, 0, 1'b0, obs);
    checkOutput("oorRdata", obs, 32'h0);
    applyStimulus(0, 1'b1, 4'd12, 32'h87654321, 4'hF, 0, 1'b0, obs);
    applyStimulus(0, 1'b0, 4'd11, 32'h0, 4'h0, 0, 1'b0, obs);
    applyStimulus(0, 1'b0, 4'd5, 32'h0, 4'h0, 0, 1'b0, obs);
    checkOutput("oorUnchanged", obs, 32'h11BB33DD);

    $display("[TB] response back-pressure");
    for (int d = 0; d < 2; d++) begin
      applyStimulus(d, 1'b0, 4'd3, 32'h0, 4'h0, 5, 1'b1, obs);
      applyStimulus(d, 1'b0, 4'd7, 32'h0, 4'h0, 0, 1'b0, obs);
      checkOutput("probeIgnored", obs, 32'h0);
    end

    $display("[TB] reset during WAIT");
    reqValid[1] = 1'b1;
    reqWr[1]    = 1'b1;
    reqAddr[1]  = 4'd3;
    reqWdata[1] = 32'hCAFEF00D;
    reqStrb[1]  = 4'hF;
    @(posedge clk); #1;
    reqValid[1] = 1'b0;
    checkOutput("waitValid", rspValid[1], 0);
    checkOutput("waitReady", reqReady[1], 0);
    reset[1] = 1'b1;
    #2;
    checkOutput("midRstValid", rspValid[1], 0);
    checkOutput("midRstReady", reqReady[1], 1);
    reset[1] = 1'b0;
    clearModel(1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkOutput("abortNoRsp", rspValid[1], 0);
    end
    applyStimulus(1, 1'b0, 4'd3, 32'h0, 4'h0, 0, 1'b0, obs);
    checkOutput("clearedRead", obs, 32'h0);

    $display("[TB] randomized transactions");
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 30; k++) begin
        applyStimulus(d, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                      4'($urandom_range(0, 15)), $urandom_range(0, 2), 1'b0, obs);
      end
    end

    $display("[TB] back-to-back bursts");
    applyBurst(0, 20);
    applyBurst(1, 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
